fir_param_seq: RTL and testbench

Parametrised, time-multiplexed FIR filter. It generalises the fixed 8th-order ECG FIR to any ORDER, with runtime-loadable coefficients, a valid/ready input handshake, and convergent-free round-half-up with saturation. It uses one MAC, iterated over the taps per sample, and sits between the ECG sample source and the output logger/comparator.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_round_sat.sv | 36 +++
 rtl/fir_param_seq.sv | 154 +++++++++++++++
 tb/tb_fir_param_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, default widths and saturation helpers for the sequential FIR family.
package fir_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_COEF_W    = 16;
    localparam int unsigned DEF_ORDER     = 8;
    localparam int unsigned DEF_FRAC_BITS = 15;
    localparam int unsigned DEF_ACC_W     = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Number of taps for a given filter order.
    function automatic int unsigned taps_f(input int unsigned order);
        return order + 1;
    endfunction

    // Largest signed value representable in w bits.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in w bits.
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up of the accumulator to DATA_W bits with clamping to the signed range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] data_c,
    output logic                     sat_c
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] R_MIN = ACC_W'(sat_min(DATA_W));

    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] r_c;

    // Add half an LSB, shift arithmetically, then clamp to the output range.
    always_comb begin
        sum_c  = acc + HALF;
        r_c    = sum_c >>> FRAC_BITS;
        data_c = r_c[DATA_W-1:0];
        sat_c  = 1'b0;
        if (r_c > R_MAX) begin
            data_c = R_MAX[DATA_W-1:0];
            sat_c  = 1'b1;
        end else if (r_c < R_MIN) begin
            data_c = R_MIN[DATA_W-1:0];
            sat_c  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_param_seq.sv
// Time-multiplexed FIR: one MAC iterated over all taps per accepted sample.
module fir_param_seq
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned COEF_W    = DEF_COEF_W,
    parameter int unsigned ORDER     = DEF_ORDER,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    localparam int unsigned TAPS     = taps_f(ORDER),
    localparam int unsigned ADDR_W   = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    if (ACC_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_acc_w_chk
        $error("fir_param_seq: ACC_W too narrow for DATA_W+COEF_W+clog2(TAPS)");
    end
    if (FRAC_BITS < 1) begin : g_frac_chk
        $error("fir_param_seq: FRAC_BITS must be at least 1");
    end

    state_t                    state;
    state_t                    state_next;
    logic                      accept_c;
    logic signed [DATA_W-1:0]  x [TAPS];
    logic signed [COEF_W-1:0]  h [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic        [ADDR_W-1:0]  idx;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [DATA_W-1:0]  rnd_data_c;
    logic                      rnd_sat_c;
    logic                      coef_ok_c;

    assign prod_c    = PROD_W'(x[idx]) * PROD_W'(h[idx]);
    assign coef_ok_c = coef_we && (state == IDLE) && (32'(coef_addr) < TAPS);

    fir_round_sat #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc    (acc),
        .data_c (rnd_data_c),
        .sat_c  (rnd_sat_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and sample-accept strobe.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (idx == ADDR_W'(ORDER)) begin
                    state_next = ROUND;
                end
            end
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Delay line: shift on accept; a coincident clear zeroes the history first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                x[k] <= '0;
            end
        end else if (accept_c) begin
            for (int k = int'(ORDER); k >= 1; k--) begin
                x[k] <= clear ? '0 : x[k-1];
            end
            x[0] <= in_data;
        end else if (clear && (state == IDLE)) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                x[k] <= '0;
            end
        end
    end

    // Coefficient store, writable only while idle and in range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                h[k] <= '0;
            end
        end else if (coef_ok_c) begin
            h[coef_addr] <= coef_wdata;
        end
    end

    // Accumulator and tap index for the MAC pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            idx <= '0;
        end else if (accept_c) begin
            acc <= '0;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= acc + ACC_W'(prod_c);
            idx <= (idx == ADDR_W'(ORDER)) ? '0 : idx + ADDR_W'(1);
        end
    end

    // Registered handshake, status and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state == ROUND);
            if (state == ROUND) begin
                out_data <= rnd_data_c;
                out_sat  <= rnd_sat_c;
            end
        end
    end

endmodule

// File: tb/tb_fir_param_seq.sv
// Directed bench for fir_param_seq with ORDER=8, 16-bit data/coefficients, Q15 output.
module tb_fir_param_seq;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fir_param_seq #(
        .DATA_W    (16),
        .COEF_W    (16),
        .ORDER     (8),
        .FRAC_BITS (15),
        .ACC_W     (40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_coef(input logic [3:0] a, input logic [15:0] v);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int k = 0; k < 9; k++) load_coef(4'(k), v);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Push one sample (optionally with clear, optionally writing h[0] while busy) and collect its result.
    task automatic send(input logic [15:0] d, input logic clr, input logic wr_busy,
                        output logic [15:0] od, output logic os);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        clear    = clr;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        if (wr_busy) begin
            coef_we    = 1'b1;
            coef_addr  = 4'd0;
            coef_wdata = 16'h7FFF;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 3) coef_we = 1'b0;
        end
        coef_we = 1'b0;
        chk("latency", 32'(n), 32'd10);
        od = out_data;
        os = out_sat;
        @(negedge clk);
        chk("ov_pulse", 32'(out_valid), 32'd0);
    endtask

    logic [15:0] od;
    logic        os;
    logic [15:0] ramp_exp [10];
    int          n;
    int          last;
    int          acc_cnt;
    int          low_cnt;
    int          ov_cnt;

    initial begin
        ramp_exp = '{16'h0000, 16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00,
                     16'hFB00, 16'hFA00, 16'hF900, 16'hF800, 16'h0000};
        reset      = 1'b0;
        clear      = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Uniform taps, impulse 0x1000
        load_all(16'h4000);
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'h1000 : 16'h0000, 1'b0, 1'b0, od, os);
            chk($sformatf("uni_d%0d", i), 32'(od), (i < 9) ? 32'h0800 : 32'h0000);
            chk($sformatf("uni_s%0d", i), 32'(os), 32'd0);
        end

        // Ramp taps, negative impulse
        for (int k = 0; k < 9; k++) load_coef(4'(k), 16'(k * 256));
        do_clear();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'h8000 : 16'h0000, 1'b0, 1'b0, od, os);
            chk($sformatf("ramp_d%0d", i), 32'(od), 32'(ramp_exp[i]));
            chk($sformatf("ramp_s%0d", i), 32'(os), 32'd0);
        end

        // Positive saturation
        load_all(16'h7FFF);
        do_clear();
        send(16'h7FFF, 1'b0, 1'b0, od, os);
        chk("psat_d0", 32'(od), 32'h7FFE);
        chk("psat_s0", 32'(os), 32'd0);
        for (int i = 1; i < 3; i++) begin
            send(16'h7FFF, 1'b0, 1'b0, od, os);
            chk($sformatf("psat_d%0d", i), 32'(od), 32'h7FFF);
            chk($sformatf("psat_s%0d", i), 32'(os), 32'd1);
        end

        // Negative saturation
        do_clear();
        send(16'h8000, 1'b0, 1'b0, od, os);
        chk("nsat_d0", 32'(od), 32'h8001);
        chk("nsat_s0", 32'(os), 32'd0);
        for (int i = 1; i < 3; i++) begin
            send(16'h8000, 1'b0, 1'b0, od, os);
            chk($sformatf("nsat_d%0d", i), 32'(od), 32'h8000);
            chk($sformatf("nsat_s%0d", i), 32'(os), 32'd1);
        end

        // Coefficient write while busy is dropped
        load_all(16'h4000);
        do_clear();
        send(16'h1000, 1'b0, 1'b1, od, os);
        chk("busy_wr_d", 32'(od), 32'h0800);
        // Idle write takes effect; clear coincident with accept drops old history
        load_coef(4'd0, 16'h7FFF);
        send(16'h1000, 1'b1, 1'b0, od, os);
        chk("idle_wr_clr_d", 32'(od), 32'h1000);
        chk("idle_wr_clr_s", 32'(os), 32'd0);
        // Out-of-range address must not alias onto any tap
        load_coef(4'd9, 16'h0000);
        for (int i = 1; i < 10; i++) begin
            send(16'h0000, 1'b0, 1'b0, od, os);
            chk($sformatf("addr9_d%0d", i), 32'(od), (i < 9) ? 32'h0800 : 32'h0000);
        end

        // Handshake with in_valid held high
        in_data  = 16'h0000;
        in_valid = 1'b1;
        acc_cnt  = 0;
        low_cnt  = 0;
        ov_cnt   = 0;
        last     = -1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                if (last >= 0) chk($sformatf("hs_gap%0d", acc_cnt), 32'(i - last), 32'd11);
                last = i;
                acc_cnt++;
            end else begin
                low_cnt++;
            end
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hs_accepts", 32'(acc_cnt), 32'd10);
        chk("hs_ready_low", 32'(low_cnt), 32'd90);
        chk("hs_pulses", 32'(ov_cnt), 32'd9);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hs_drain", 32'(n), 32'd10);
        @(negedge clk);

        // Reset during MAC aborts the pass
        load_all(16'h4000);
        do_clear();
        in_data  = 16'h1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_ov", 32'(n), 32'd0);
        chk("abort_data_hold", 32'(out_data), 32'd0);
        load_all(16'h4000);
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'h1000 : 16'h0000, 1'b0, 1'b0, od, os);
            chk($sformatf("post_rst_d%0d", i), 32'(od), (i < 9) ? 32'h0800 : 32'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
